combo_entry_ctrl: RTL and testbench
===================================

Name: combo_entry_ctrl

Overview:
- Sequencing controller for the combination-lock datapath, replacing the ad-hoc main/digit FSM pair.
- Turns synchronized keypad strobes into one clean key event per press.
- Drives digit writes into the shared 6-digit entry buffer and commits or checks the password.
- Counts failed attempts and enforces a timed lockout after MAX_FAILS consecutive failures.

Parameters:
- NUM_DIGITS, 6: digits per password/attempt.
- SAMPLE_CYCLES, 3: consecutive valid-high cycles that qualify a press.
- MAX_FAILS, 3: failed attempts before lockout.
- LOCKOUT_CYCLES, 250_000_000: lockout duration in clocks (5 s at 50 MHz).

Ports:
- MAX10_CLK1_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  synchronized keypad valid, active high.
- key_code  in  4  synchronized keypad code.
- match  in  1  datapath compare result, password == attempt.
- state  out  3  current controller state (combo_pkg encoding).
- digit_we  out  1  buffer write strobe, one cycle.
- digit_idx  out  3  buffer slot 0..NUM_DIGITS-1, MSD = 0.
- digit_val  out  4  digit to write.
- buf_clear  out  1  one-cycle pulse: datapath loads buffer with 0x111111.
- set_pw_stb  out  1  one-cycle pulse: datapath copies buffer to password.
- check_stb  out  1  one-cycle pulse: datapath copies buffer to attempt; match sampled.
- fail_cnt  out  2  consecutive failed attempts.
- lockout  out  1  high while in LOCKOUT.

Behaviour:
Fixed decisions:
- One clock; reset is synchronous and active-high; ports named MAX10_CLK1_50 and reset.
- Reset dominates all other inputs.

Reset values:
- state=OPEN, fail_cnt=0, digit_idx=0.
- All strobes 0, lockout=0, sampler counter 0, lockout timer 0.

Key sampler:
- Counter increments while key_valid=1 and saturates at SAMPLE_CYCLES.
- Counter clears on any cycle with key_valid=0.
- On the cycle the counter reaches SAMPLE_CYCLES, key_code is captured and key_evt pulses for exactly one cycle.
- A held key never re-fires.

Key classes:
- Digit: 0-9.
- ENTER: 0xE.
- CLEAR: 0xF.
- 0xA-0xD are ignored in every state.

FSM action timing:
- The FSM acts on key_evt the same cycle key_evt is high.
- Resulting strobes are registered and visible on the next cycle.
- Latency from the SAMPLE_CYCLES-th high cycle to digit_we is 1 clock.

States:
- OPEN:
  - digit -> SET_ENTRY; write slot 0; idx becomes 1.
  - ENTER/CLEAR ignored.
- SET_ENTRY:
  - digit with idx<NUM_DIGITS: write slot idx, idx++.
  - digit with idx==NUM_DIGITS: ignored (no write).
  - ENTER with idx==NUM_DIGITS: pulse set_pw_stb and buf_clear, idx=0, go to LOCKED.
  - ENTER with idx<NUM_DIGITS: ignored.
  - CLEAR: pulse buf_clear, idx=0, go to OPEN.
- LOCKED:
  - digit -> ATT_ENTRY; write slot 0; idx becomes 1.
  - ENTER/CLEAR ignored.
- ATT_ENTRY:
  - Digit and ENTER rules same as SET_ENTRY, except a full ENTER goes to CHECK.
  - CLEAR: pulse buf_clear, idx=0, go to LOCKED.
- CHECK:
  - Lasts exactly one cycle; check_stb is high during it; match is sampled at the end.
  - match=1: fail_cnt=0, pulse buf_clear, go to OPEN.
  - match=0 and fail_cnt+1==MAX_FAILS: load timer with LOCKOUT_CYCLES-1, go to LOCKOUT.
  - match=0 otherwise: fail_cnt++, pulse buf_clear, go to LOCKED.
- LOCKOUT:
  - lockout=1; all key events ignored; timer counts down.
  - At timer==0: fail_cnt=0, pulse buf_clear, go to LOCKED.
  - The sampler keeps running, so a key held across expiry does not fire.

Width rules:
- fail_cnt never exceeds MAX_FAILS-1 outside LOCKOUT.
- In LOCKOUT, fail_cnt reads MAX_FAILS, saturated; MAX_FAILS<=3.
- Timer width is $clog2(LOCKOUT_CYCLES).
- digit_idx counts 0..NUM_DIGITS.

Reset mid-entry:
- Buffer contents are the datapath's concern.
- The controller returns to OPEN and issues no strobe during reset.

Decomposition:
- combo_pkg holds:
  - ctrl_state_t enum: OPEN=0, SET_ENTRY=1, LOCKED=4, ATT_ENTRY=5, CHECK=6, LOCKOUT=7.
  - Key constants: KEY_ENTER=4'hE, KEY_CLEAR=4'hF.
  - BUF_INIT=24'h111111.
- Sub-module combo_key_sampler holds the counter and capture logic (ports: clock, reset, key_valid, key_code, key_evt, key_val).

Test Plan:
Bench parameters: SAMPLE_CYCLES=3, LOCKOUT_CYCLES=20.
- Hold key_valid high for 2 cycles with code 5 -> no digit_we. Hold 10 cycles with code 5 -> exactly one digit_we (idx 0, val 5), 1 clock after the 3rd high cycle.
- From OPEN enter 1,2,3,4,5,6 then E -> six writes at idx 0..5, then set_pw_stb=1 for one cycle, state=LOCKED. A 7th digit before E -> no write.
- In LOCKED enter six digits and E, match=1 -> check_stb for one cycle, then state=OPEN, fail_cnt=0. Enter 3 digits then E -> ignored, state stays ATT_ENTRY.
- Three full attempts with match=0 -> fail_cnt 1, then 2, then LOCKOUT with lockout=1. Keys during lockout -> no writes. After 20 cycles -> LOCKED, fail_cnt=0.
- Enter 4 digits in ATT_ENTRY then F -> buf_clear, idx=0, state=LOCKED. In SET_ENTRY, F -> state=OPEN.
- Assert reset during ATT_ENTRY at idx 3 -> next cycle state=OPEN, idx=0, all strobes 0.

Source files
------------

// File: rtl/combo_pkg.sv
// Shared types and constants for the combination-lock entry controller.
package combo_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned KEY_W   = 4;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned FAIL_W  = 2;
    localparam int unsigned BUF_W   = 24;

    typedef enum logic [STATE_W-1:0] {
        OPEN      = 3'd0,
        SET_ENTRY = 3'd1,
        LOCKED    = 3'd4,
        ATT_ENTRY = 3'd5,
        CHECK     = 3'd6,
        LOCKOUT   = 3'd7
    } ctrl_state_t;

    localparam logic [KEY_W-1:0] KEY_ENTER = 4'hE;
    localparam logic [KEY_W-1:0] KEY_CLEAR = 4'hF;
    localparam logic [BUF_W-1:0] BUF_INIT  = 24'h111111;

    function automatic logic is_digit(input logic [KEY_W-1:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/combo_entry_ctrl_if.sv
// Keypad-in / datapath-out signal bundle of the entry controller.
interface combo_entry_ctrl_if;

    logic                          key_valid;
    logic [combo_pkg::KEY_W-1:0]   key_code;
    logic                          match;
    logic [combo_pkg::STATE_W-1:0] state;
    logic                          digit_we;
    logic [combo_pkg::IDX_W-1:0]   digit_idx;
    logic [combo_pkg::KEY_W-1:0]   digit_val;
    logic                          buf_clear;
    logic                          set_pw_stb;
    logic                          check_stb;
    logic [combo_pkg::FAIL_W-1:0]  fail_cnt;
    logic                          lockout;

    modport master (
        output key_valid, key_code, match,
        input  state, digit_we, digit_idx, digit_val, buf_clear,
               set_pw_stb, check_stb, fail_cnt, lockout
    );

    modport slave (
        input  key_valid, key_code, match,
        output state, digit_we, digit_idx, digit_val, buf_clear,
               set_pw_stb, check_stb, fail_cnt, lockout
    );

endinterface

// File: rtl/combo_key_sampler.sv
// Qualifies a keypad press after SAMPLE_CYCLES consecutive valid cycles; fires once per press.
module combo_key_sampler
    import combo_pkg::*;
#(
    parameter int unsigned SAMPLE_CYCLES = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_key_valid,
    input  logic [KEY_W-1:0] i_key_code,
    output logic             o_key_evt_c,
    output logic [KEY_W-1:0] o_key_val_c
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Saturating run-length counter; any low cycle restarts qualification.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_key_valid) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_W'(SAMPLE_CYCLES)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Event on the qualifying cycle itself so the FSM registers its action one clock later.
    assign o_key_evt_c = i_key_valid && (r_cnt == CNT_W'(SAMPLE_CYCLES - 1));
    assign o_key_val_c = i_key_code;

endmodule

// File: rtl/combo_entry_ctrl.sv
// Combination-lock sequencing controller: key events to buffer writes, password set/check, lockout.
module combo_entry_ctrl
    import combo_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 6,
    parameter int unsigned SAMPLE_CYCLES  = 3,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 250_000_000
) (
    input  logic               MAX10_CLK1_50,
    input  logic               reset,
    combo_entry_ctrl_if.slave  bus
);

    localparam int unsigned TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    ctrl_state_t       r_state, w_state_nx;
    logic [IDX_W-1:0]  r_idx, w_idx_nx;
    logic [FAIL_W-1:0] r_fail, w_fail_nx;
    logic [TMR_W-1:0]  r_timer, w_timer_nx;
    logic              r_digit_we, w_digit_we_nx;
    logic [IDX_W-1:0]  r_digit_idx, w_digit_idx_nx;
    logic [KEY_W-1:0]  r_digit_val, w_digit_val_nx;
    logic              r_buf_clear, w_buf_clear_nx;
    logic              r_set_pw, w_set_pw_nx;
    logic              r_check, w_check_nx;
    logic              r_lockout, w_lockout_nx;

    logic              w_key_evt;
    logic [KEY_W-1:0]  w_key_val;
    logic              w_is_digit;
    logic              w_full;

    combo_key_sampler #(
        .SAMPLE_CYCLES (SAMPLE_CYCLES)
    ) u_sampler (
        .i_clk       (MAX10_CLK1_50),
        .i_rst       (reset),
        .i_key_valid (bus.key_valid),
        .i_key_code  (bus.key_code),
        .o_key_evt_c (w_key_evt),
        .o_key_val_c (w_key_val)
    );

    assign w_is_digit = is_digit(w_key_val);
    assign w_full     = (r_idx == IDX_W'(NUM_DIGITS));

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            r_state     <= OPEN;
            r_idx       <= '0;
            r_fail      <= '0;
            r_timer     <= '0;
            r_digit_we  <= 1'b0;
            r_digit_idx <= '0;
            r_digit_val <= '0;
            r_buf_clear <= 1'b0;
            r_set_pw    <= 1'b0;
            r_check     <= 1'b0;
            r_lockout   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_idx       <= w_idx_nx;
            r_fail      <= w_fail_nx;
            r_timer     <= w_timer_nx;
            r_digit_we  <= w_digit_we_nx;
            r_digit_idx <= w_digit_idx_nx;
            r_digit_val <= w_digit_val_nx;
            r_buf_clear <= w_buf_clear_nx;
            r_set_pw    <= w_set_pw_nx;
            r_check     <= w_check_nx;
            r_lockout   <= w_lockout_nx;
        end
    end

    // Next state and next registered outputs; strobes default low every cycle.
    always_comb begin
        w_state_nx     = r_state;
        w_idx_nx       = r_idx;
        w_fail_nx      = r_fail;
        w_timer_nx     = r_timer;
        w_digit_we_nx  = 1'b0;
        w_digit_idx_nx = r_digit_idx;
        w_digit_val_nx = r_digit_val;
        w_buf_clear_nx = 1'b0;
        w_set_pw_nx    = 1'b0;
        w_check_nx     = 1'b0;
        w_lockout_nx   = 1'b0;

        case (r_state)
            OPEN, LOCKED: begin
                if (w_key_evt && w_is_digit) begin
                    w_state_nx     = (r_state == OPEN) ? SET_ENTRY : ATT_ENTRY;
                    w_digit_we_nx  = 1'b1;
                    w_digit_idx_nx = '0;
                    w_digit_val_nx = w_key_val;
                    w_idx_nx       = IDX_W'(1);
                end
            end
            SET_ENTRY, ATT_ENTRY: begin
                if (w_key_evt) begin
                    if (w_is_digit && !w_full) begin
                        w_digit_we_nx  = 1'b1;
                        w_digit_idx_nx = r_idx;
                        w_digit_val_nx = w_key_val;
                        w_idx_nx       = r_idx + IDX_W'(1);
                    end else if (w_key_val == KEY_ENTER && w_full) begin
                        w_idx_nx = '0;
                        if (r_state == SET_ENTRY) begin
                            w_set_pw_nx    = 1'b1;
                            w_buf_clear_nx = 1'b1;
                            w_digit_idx_nx = '0;
                            w_state_nx     = LOCKED;
                        end else begin
                            // Buffer must survive until the attempt is copied in CHECK.
                            w_check_nx = 1'b1;
                            w_state_nx = CHECK;
                        end
                    end else if (w_key_val == KEY_CLEAR) begin
                        w_buf_clear_nx = 1'b1;
                        w_idx_nx       = '0;
                        w_digit_idx_nx = '0;
                        w_state_nx     = (r_state == SET_ENTRY) ? OPEN : LOCKED;
                    end
                end
            end
            CHECK: begin
                if (bus.match) begin
                    w_fail_nx      = '0;
                    w_buf_clear_nx = 1'b1;
                    w_digit_idx_nx = '0;
                    w_state_nx     = OPEN;
                end else if (32'(r_fail) + 32'd1 == MAX_FAILS) begin
                    w_timer_nx   = TMR_W'(LOCKOUT_CYCLES - 1);
                    w_fail_nx    = FAIL_W'(MAX_FAILS);
                    w_lockout_nx = 1'b1;
                    w_state_nx   = LOCKOUT;
                end else begin
                    w_fail_nx      = r_fail + FAIL_W'(1);
                    w_buf_clear_nx = 1'b1;
                    w_digit_idx_nx = '0;
                    w_state_nx     = LOCKED;
                end
            end
            LOCKOUT: begin
                if (r_timer == '0) begin
                    w_fail_nx      = '0;
                    w_buf_clear_nx = 1'b1;
                    w_digit_idx_nx = '0;
                    w_state_nx     = LOCKED;
                end else begin
                    w_timer_nx   = r_timer - TMR_W'(1);
                    w_lockout_nx = 1'b1;
                end
            end
            default: w_state_nx = OPEN;
        endcase
    end

    assign bus.state      = r_state;
    assign bus.digit_we   = r_digit_we;
    assign bus.digit_idx  = r_digit_idx;
    assign bus.digit_val  = r_digit_val;
    assign bus.buf_clear  = r_buf_clear;
    assign bus.set_pw_stb = r_set_pw;
    assign bus.check_stb  = r_check;
    assign bus.fail_cnt   = r_fail;
    assign bus.lockout    = r_lockout;

endmodule

// File: tb/tb_combo_entry_ctrl.sv
// Scoreboard bench for combo_entry_ctrl: expected buffer writes queued at stimulus, popped on digit_we.
module tb_combo_entry_ctrl;
    import combo_pkg::*;

    localparam int unsigned NUM_DIGITS     = 6;
    localparam int unsigned SAMPLE_CYCLES  = 3;
    localparam int unsigned MAX_FAILS      = 3;
    localparam int unsigned LOCKOUT_CYCLES = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    combo_entry_ctrl_if bus ();

    combo_entry_ctrl #(
        .NUM_DIGITS     (NUM_DIGITS),
        .SAMPLE_CYCLES  (SAMPLE_CYCLES),
        .MAX_FAILS      (MAX_FAILS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .reset         (rst),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];           // {slot, digit}
    logic [6:0] mon_exp;
    int n_clr = 0, n_setpw = 0, n_chk = 0, n_lock = 0;
    logic p_clr = 1'b0, p_setpw = 1'b0, p_chk = 1'b0;

    // Monitor: scoreboard for writes, pulse counters, single-cycle strobe checks.
    always @(negedge clk) begin
        if (bus.digit_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected got idx=%0d val=%0h want no write", bus.digit_idx, bus.digit_val);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.digit_idx, bus.digit_val} !== mon_exp) begin
                    errors++;
                    $display("FAIL write_data got idx=%0d val=%0h want idx=%0d val=%0h",
                             bus.digit_idx, bus.digit_val, mon_exp[6:4], mon_exp[3:0]);
                end
            end
        end
        if (bus.buf_clear === 1'b1) begin
            n_clr++; checks++;
            if (p_clr) begin errors++; $display("FAIL buf_clear_width got 2+ cycles want 1"); end
        end
        if (bus.set_pw_stb === 1'b1) begin
            n_setpw++; checks++;
            if (p_setpw) begin errors++; $display("FAIL set_pw_width got 2+ cycles want 1"); end
        end
        if (bus.check_stb === 1'b1) begin
            n_chk++; checks++;
            if (p_chk) begin errors++; $display("FAIL check_width got 2+ cycles want 1"); end
        end
        if (bus.lockout === 1'b1) n_lock++;
        p_clr   = bus.buf_clear;
        p_setpw = bus.set_pw_stb;
        p_chk   = bus.check_stb;
    end

    // Tasks are entered and left just after a falling edge.
    task automatic press(input logic [3:0] code, input int hold, input bit exp_we, input logic [2:0] exp_idx);
        if (exp_we) exp_q.push_back({exp_idx, code});
        for (int i = 0; i < hold; i++) begin
            bus.key_valid = 1'b1;
            bus.key_code  = code;
            @(negedge clk);
        end
        bus.key_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic set_pw();
        for (int i = 0; i < NUM_DIGITS; i++) press(4'(i + 1), 3, 1'b1, 3'(i));
        press(KEY_ENTER, 3, 1'b0, 3'd0);
    endtask

    task automatic attempt(input logic m);
        bus.match = m;
        for (int i = 0; i < NUM_DIGITS; i++) press(4'(9 - i), 3, 1'b1, 3'(i));
        press(KEY_ENTER, 3, 1'b0, 3'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.key_valid = 1'b0; bus.key_code = '0; bus.match = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.state !== OPEN) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
        checks++;
        if (bus.fail_cnt !== 2'd0 || bus.digit_idx !== 3'd0) begin
            errors++; $display("FAIL reset_cnt got fail=%0d idx=%0d want 0 0", bus.fail_cnt, bus.digit_idx);
        end
        checks++;
        if ({bus.digit_we, bus.buf_clear, bus.set_pw_stb, bus.check_stb, bus.lockout} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes got %b want 00000",
                {bus.digit_we, bus.buf_clear, bus.set_pw_stb, bus.check_stb, bus.lockout});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sampler();
        press(4'd5, 2, 1'b0, 3'd0);
        checks++;
        if (bus.state !== OPEN) begin errors++; $display("FAIL short_press_state got %0d want 0", bus.state); end
        exp_q.push_back({3'd0, 4'd5});
        bus.key_valid = 1'b1; bus.key_code = 4'd5;
        @(negedge clk); @(negedge clk);
        checks++;
        if (bus.digit_we !== 1'b0) begin errors++; $display("FAIL early_we got %b want 0", bus.digit_we); end
        @(negedge clk);
        checks++;
        if (bus.digit_we !== 1'b1) begin errors++; $display("FAIL latency_we got %b want 1", bus.digit_we); end
        repeat (7) @(negedge clk);
        bus.key_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (bus.state !== SET_ENTRY) begin errors++; $display("FAIL held_state got %0d want 1", bus.state); end
    endtask

    task automatic test_set_clear();
        int c0;
        c0 = n_clr;
        press(KEY_CLEAR, 3, 1'b0, 3'd0);
        checks++;
        if (bus.state !== OPEN || n_clr != c0 + 1) begin
            errors++; $display("FAIL set_clear got state=%0d clr=%0d want 0 %0d", bus.state, n_clr - c0, 1);
        end
    endtask

    task automatic test_set_password();
        int s0, c0;
        for (int i = 0; i < 3; i++) press(4'(i + 1), 3, 1'b1, 3'(i));
        press(KEY_ENTER, 3, 1'b0, 3'd0);
        checks++;
        if (bus.state !== SET_ENTRY) begin errors++; $display("FAIL early_enter got %0d want 1", bus.state); end
        for (int i = 3; i < NUM_DIGITS; i++) press(4'(i + 1), 3, 1'b1, 3'(i));
        press(4'd7, 3, 1'b0, 3'd0);
        press(4'hB, 3, 1'b0, 3'd0);
        s0 = n_setpw; c0 = n_clr;
        press(KEY_ENTER, 3, 1'b0, 3'd0);
        checks++;
        if (bus.state !== LOCKED) begin errors++; $display("FAIL set_state got %0d want 4", bus.state); end
        checks++;
        if (n_setpw != s0 + 1 || n_clr != c0 + 1) begin
            errors++; $display("FAIL set_strobes got setpw=%0d clr=%0d want 1 1", n_setpw - s0, n_clr - c0);
        end
    endtask

    task automatic test_match();
        int k0;
        press(KEY_ENTER, 3, 1'b0, 3'd0);
        checks++;
        if (bus.state !== LOCKED) begin errors++; $display("FAIL locked_enter got %0d want 4", bus.state); end
        bus.match = 1'b1;
        for (int i = 0; i < 3; i++) press(4'(i), 3, 1'b1, 3'(i));
        press(KEY_ENTER, 3, 1'b0, 3'd0);
        checks++;
        if (bus.state !== ATT_ENTRY) begin errors++; $display("FAIL att_partial got %0d want 5", bus.state); end
        for (int i = 3; i < NUM_DIGITS; i++) press(4'(i), 3, 1'b1, 3'(i));
        k0 = n_chk;
        press(KEY_ENTER, 3, 1'b0, 3'd0);
        checks++;
        if (bus.state !== OPEN || bus.fail_cnt !== 2'd0 || n_chk != k0 + 1) begin
            errors++; $display("FAIL match got state=%0d fail=%0d chk=%0d want 0 0 1", bus.state, bus.fail_cnt, n_chk - k0);
        end
        bus.match = 1'b0;
        set_pw();
    endtask

    task automatic test_fail_lockout();
        int l0;
        bit done;
        l0 = n_lock;
        for (int a = 1; a < int'(MAX_FAILS); a++) begin
            attempt(1'b0);
            checks++;
            if (bus.state !== LOCKED || bus.fail_cnt !== 2'(a)) begin
                errors++; $display("FAIL fail_%0d got state=%0d fail=%0d want 4 %0d", a, bus.state, bus.fail_cnt, a);
            end
        end
        attempt(1'b0);
        checks++;
        if (bus.state !== LOCKOUT || bus.lockout !== 1'b1 || bus.fail_cnt !== 2'(MAX_FAILS)) begin
            errors++; $display("FAIL lockout_entry got state=%0d lock=%b fail=%0d want 7 1 %0d",
                               bus.state, bus.lockout, bus.fail_cnt, MAX_FAILS);
        end
        press(4'd2, 3, 1'b0, 3'd0);
        press(KEY_ENTER, 3, 1'b0, 3'd0);
        checks++;
        if (bus.state !== LOCKOUT) begin errors++; $display("FAIL lockout_keys got %0d want 7", bus.state); end
        press(4'd4, 15, 1'b0, 3'd0);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (bus.state === LOCKED) done = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!done) begin errors++; $display("FAIL lockout_exit got state=%0d want 4 within 40 cycles", bus.state); end
        checks++;
        if (bus.fail_cnt !== 2'd0 || n_lock - l0 != int'(LOCKOUT_CYCLES)) begin
            errors++; $display("FAIL lockout_len got fail=%0d cycles=%0d want 0 %0d", bus.fail_cnt, n_lock - l0, LOCKOUT_CYCLES);
        end
    endtask

    task automatic test_att_clear();
        int c0;
        for (int i = 0; i < 4; i++) press(4'(i + 6), 3, 1'b1, 3'(i));
        c0 = n_clr;
        press(KEY_CLEAR, 3, 1'b0, 3'd0);
        checks++;
        if (bus.state !== LOCKED || bus.digit_idx !== 3'd0 || n_clr != c0 + 1) begin
            errors++; $display("FAIL att_clear got state=%0d idx=%0d clr=%0d want 4 0 1", bus.state, bus.digit_idx, n_clr - c0);
        end
        press(4'd8, 3, 1'b1, 3'd0);
        checks++;
        if (bus.state !== ATT_ENTRY) begin errors++; $display("FAIL after_clear got %0d want 5", bus.state); end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i < 3; i++) press(4'(i), 3, 1'b1, 3'(i));
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.state !== OPEN || bus.digit_idx !== 3'd0) begin
            errors++; $display("FAIL mid_reset got state=%0d idx=%0d want 0 0", bus.state, bus.digit_idx);
        end
        checks++;
        if ({bus.digit_we, bus.buf_clear, bus.set_pw_stb, bus.check_stb, bus.lockout} !== 5'b0) begin
            errors++; $display("FAIL mid_reset_strobes got %b want 00000",
                {bus.digit_we, bus.buf_clear, bus.set_pw_stb, bus.check_stb, bus.lockout});
        end
        rst = 1'b0;
        @(negedge clk);
        press(4'd3, 3, 1'b1, 3'd0);
        checks++;
        if (bus.state !== SET_ENTRY) begin errors++; $display("FAIL post_reset got %0d want 1", bus.state); end
    endtask

    initial begin
        bus.key_valid = 1'b0; bus.key_code = '0; bus.match = 1'b0;
        @(negedge clk);
        test_reset();
        test_sampler();
        test_set_clear();
        test_set_password();
        test_match();
        test_fail_lockout();
        test_att_clear();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL missing_writes got %0d pending want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
